itch_mold_framer: RTL and testbench

- Parametrised successor to the single-stream ITCH front end.
- Consumes a raw captured frame byte stream: Ethernet/VLAN/IPv4/UDP headers, then MoldUDP64.
- Strips the headers and decodes the MoldUDP64 header. Splits the payload into individual length-delimited ITCH messages, each tagged with its own sequence number.
- Feeds the per-message-type field decoders. Adds in_valid gaps, frame framing, heartbeat/end-of-session handling and error reporting.

---
 rtl/itch_mold_framer_if.sv | 26 ++
 rtl/itch_mold_framer.sv | 208 ++++++++++++++++++++
 tb/tb_itch_mold_framer.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/itch_mold_framer_if.sv
// Byte-stream bundle for itch_mold_framer: raw frame bytes in, delimited ITCH message bytes out.
// The slave modport is the framer side; the master modport is the frame source / message sink.
interface itch_mold_framer_if #(
  parameter int LEN_W = 16
) ();
  logic             in_valid;
  logic [7:0]       in_byte;
  logic             in_last;
  logic             out_valid;
  logic [7:0]       out_byte;
  logic             out_first;
  logic             out_last;
  logic [LEN_W-1:0] out_len;
  logic [63:0]      out_seq;
  logic [79:0]      out_session;

  modport master (
    output in_valid, in_byte, in_last,
    input  out_valid, out_byte, out_first, out_last, out_len, out_seq, out_session
  );

  modport slave (
    input  in_valid, in_byte, in_last,
    output out_valid, out_byte, out_first, out_last, out_len, out_seq, out_session
  );
endinterface

// File: rtl/itch_mold_framer.sv
// Strips Ethernet/IP/UDP headers, decodes MoldUDP64 and splits the payload into ITCH messages.
// Optional SEQ_GAP_CHECK_EN adds a seq_gap pulse on unexpected packet sequence numbers.
module itch_mold_framer #(
  parameter int HDR_LEN     = 46,
  parameter int MAX_MSG_LEN = 64,
  parameter int LEN_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  itch_mold_framer_if.slave bus,
  output logic              hb_pulse,
  output logic              eos_pulse,
  output logic              err_len,
  output logic              err_trunc
`ifdef SEQ_GAP_CHECK_EN
  ,
  output logic              seq_gap
`endif
);

  localparam logic [2:0] S_HDR    = 3'd0;
  localparam logic [2:0] S_MOLD   = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_LEN_LO = 3'd3;
  localparam logic [2:0] S_BODY   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  logic [2:0]       state;
  logic [15:0]      pos;
  logic [79:0]      session_sh;
  logic [63:0]      seq_sh;
  logic [7:0]       cnt_hi;
  logic [15:0]      msg_count;
  logic [15:0]      msg_idx;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] msg_len;
  logic [LEN_W-1:0] body_cnt;

  logic             o_valid;
  logic [7:0]       o_byte;
  logic             o_first;
  logic             o_last;
  logic [LEN_W-1:0] o_len;
  logic [63:0]      o_seq;
  logic [79:0]      o_session;

`ifdef SEQ_GAP_CHECK_EN
  logic [63:0]      exp_seq;
`endif

  logic [15:0] mold_count;
  logic [15:0] len_val;
  logic        len_bad;
  logic        hdr_done;
  logic        mold_done;
  logic        msg_end;
  logic        last_msg;
  logic        trunc;

  assign mold_count = {cnt_hi, bus.in_byte};
  assign len_val    = {len_hi, bus.in_byte};
  assign len_bad    = (len_val == '0) || (len_val > 16'(MAX_MSG_LEN));
  assign hdr_done   = (pos == 16'(HDR_LEN - 1));
  assign mold_done  = (pos == 16'd19);
  assign msg_end    = (body_cnt == LEN_W'(1));
  assign last_msg   = (msg_idx == msg_count - 16'd1);

  // A heartbeat/end-of-session header ending the frame is complete, not truncated.
  always_comb begin
    trunc = 1'b1;
    case (state)
      S_MOLD:  trunc = !(mold_done && (mold_count == '0 || mold_count == '1));
      S_BODY:  trunc = !(msg_end && last_msg);
      S_DRAIN: trunc = 1'b0;
      default: trunc = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_HDR;
      pos        <= '0;
      session_sh <= '0;
      seq_sh     <= '0;
      cnt_hi     <= '0;
      msg_count  <= '0;
      msg_idx    <= '0;
      len_hi     <= '0;
      msg_len    <= '0;
      body_cnt   <= '0;
      o_valid    <= 1'b0;
      o_byte     <= '0;
      o_first    <= 1'b0;
      o_last     <= 1'b0;
      o_len      <= '0;
      o_seq      <= '0;
      o_session  <= '0;
      hb_pulse   <= 1'b0;
      eos_pulse  <= 1'b0;
      err_len    <= 1'b0;
      err_trunc  <= 1'b0;
`ifdef SEQ_GAP_CHECK_EN
      seq_gap    <= 1'b0;
      exp_seq    <= '0;
`endif
    end else begin
      o_valid   <= 1'b0;
      hb_pulse  <= 1'b0;
      eos_pulse <= 1'b0;
      err_len   <= 1'b0;
      err_trunc <= 1'b0;
`ifdef SEQ_GAP_CHECK_EN
      seq_gap   <= 1'b0;
`endif
      if (bus.in_valid) begin
        case (state)
          S_HDR: begin
            pos <= pos + 16'd1;
            if (hdr_done) begin
              pos   <= '0;
              state <= S_MOLD;
            end
          end
          S_MOLD: begin
            pos <= pos + 16'd1;
            if (pos < 16'd10) begin
              session_sh <= {session_sh[71:0], bus.in_byte};
            end else if (pos < 16'd18) begin
              seq_sh <= {seq_sh[55:0], bus.in_byte};
            end else if (pos == 16'd18) begin
              cnt_hi <= bus.in_byte;
            end else begin
              pos       <= '0;
              msg_count <= mold_count;
              msg_idx   <= '0;
              o_seq     <= seq_sh;
              o_session <= session_sh;
              if (mold_count == '0) begin
                hb_pulse <= 1'b1;
                state    <= S_DRAIN;
              end else if (mold_count == '1) begin
                eos_pulse <= 1'b1;
                state     <= S_DRAIN;
              end else begin
                state <= S_LEN_HI;
              end
`ifdef SEQ_GAP_CHECK_EN
              // Zero doubles as "no expectation yet".
              if (mold_count != '1) begin
                seq_gap <= (exp_seq != '0) && (seq_sh != exp_seq);
                exp_seq <= seq_sh + 64'(mold_count);
              end
`endif
            end
          end
          S_LEN_HI: begin
            len_hi <= bus.in_byte;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            if (len_bad) begin
              err_len <= 1'b1;
              state   <= S_DRAIN;
            end else begin
              msg_len  <= LEN_W'(len_val);
              body_cnt <= LEN_W'(len_val);
              state    <= S_BODY;
            end
          end
          S_BODY: begin
            o_valid  <= 1'b1;
            o_byte   <= bus.in_byte;
            o_first  <= (body_cnt == msg_len);
            o_last   <= msg_end || bus.in_last;
            o_len    <= msg_len;
            o_seq    <= seq_sh + 64'(msg_idx);
            body_cnt <= body_cnt - LEN_W'(1);
            if (msg_end) begin
              msg_idx <= msg_idx + 16'd1;
              state   <= last_msg ? S_DRAIN : S_LEN_HI;
            end
          end
          S_DRAIN: ;
          default: state <= S_HDR;
        endcase

        // End of frame overrides whatever the state decode chose above.
        if (bus.in_last) begin
          state     <= S_HDR;
          pos       <= '0;
          msg_idx   <= '0;
          msg_count <= '0;
          body_cnt  <= '0;
          err_trunc <= trunc;
        end
      end
    end
  end

  assign bus.out_valid   = o_valid;
  assign bus.out_byte    = o_byte;
  assign bus.out_first   = o_first;
  assign bus.out_last    = o_last;
  assign bus.out_len     = o_len;
  assign bus.out_seq     = o_seq;
  assign bus.out_session = o_session;

endmodule

// File: tb/tb_itch_mold_framer.sv
// Scoreboard bench for itch_mold_framer: frames are parsed by a reference model into expected
// message bytes and pulse events; monitors compare them against the DUT as outputs appear.
module tb_itch_mold_framer;
  localparam int H    = 46;
  localparam int MAXL = 64;
  localparam int LW   = 16;
  localparam logic [4:0] P_TRUNC = 5'b00001;
  localparam logic [4:0] P_ELEN  = 5'b00010;

  logic clk = 1'b0;
  logic reset;
  logic hb_pulse, eos_pulse, err_len, err_trunc, seq_gap;

  always #5 clk = ~clk;

  itch_mold_framer_if #(.LEN_W(LW)) bus ();

  itch_mold_framer #(.HDR_LEN(H), .MAX_MSG_LEN(MAXL), .LEN_W(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .hb_pulse  (hb_pulse),
    .eos_pulse (eos_pulse),
    .err_len   (err_len),
`ifdef SEQ_GAP_CHECK_EN
    .err_trunc (err_trunc),
    .seq_gap   (seq_gap)
`else
    .err_trunc (err_trunc)
`endif
  );

`ifndef SEQ_GAP_CHECK_EN
  assign seq_gap = 1'b0;
`endif

  typedef struct {
    logic [7:0]    b;
    logic          first;
    logic          last;
    logic [LW-1:0] len;
    logic [63:0]   seq;
    logic [79:0]   ses;
  } rec_t;

  rec_t        bq[$];
  logic [4:0]  pq[$];
  logic [7:0]  frame[$];
  int          lens[$];
  logic [7:0]  types[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_seq = '0;
  logic        acc_prev = 1'b0;
  logic [7:0]  acc_byte = '0;
  rec_t        e_rec;
  logic [4:0]  pv, pe;

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    acc_prev <= bus.in_valid && !reset;
    acc_byte <= bus.in_byte;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid) begin
        checks++;
        if (!acc_prev || bus.out_byte !== acc_byte) begin
          errors++;
          $display("FAIL latency: out_byte=%02h, required byte accepted one cycle earlier (accepted=%0b byte=%02h)",
                   bus.out_byte, acc_prev, acc_byte);
        end
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got out_byte=%02h, no message byte expected", bus.out_byte);
        end else begin
          e_rec = bq.pop_front();
          if (bus.out_byte !== e_rec.b || bus.out_first !== e_rec.first || bus.out_last !== e_rec.last ||
              bus.out_len !== e_rec.len || bus.out_seq !== e_rec.seq || bus.out_session !== e_rec.ses) begin
            errors++;
            $display("FAIL byte: got b=%02h f=%0b l=%0b len=%0d seq=%h ses=%h, required b=%02h f=%0b l=%0b len=%0d seq=%h ses=%h",
                     bus.out_byte, bus.out_first, bus.out_last, bus.out_len, bus.out_seq, bus.out_session,
                     e_rec.b, e_rec.first, e_rec.last, e_rec.len, e_rec.seq, e_rec.ses);
          end
        end
      end
      pv = {seq_gap, hb_pulse, eos_pulse, err_len, err_trunc};
      if (pv != '0) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got {gap,hb,eos,len,trunc}=%05b, none expected", pv);
        end else begin
          pe = pq.pop_front();
          if (pv !== pe) begin
            errors++;
            $display("FAIL pulse: got {gap,hb,eos,len,trunc}=%05b, required %05b", pv, pe);
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int blen(input int l);
    return (l >= 1 && l <= MAXL) ? l : 4;
  endfunction

  task automatic model_frame(input int n, input bit has_last);
    logic [79:0] ses;
    logic [63:0] seq;
    logic [4:0]  v;
    int cnt, p, idx, len, avail, k;
    rec_t r;
    if (n < H + 20) begin
      if (has_last) pq.push_back(P_TRUNC);
      return;
    end
    ses = '0;
    seq = '0;
    for (int i = 0; i < 10; i++) ses = {ses[71:0], frame[H+i]};
    for (int i = 0; i < 8; i++) seq = {seq[55:0], frame[H+10+i]};
    cnt = int'({frame[H+18], frame[H+19]});
    v = '0;
`ifdef SEQ_GAP_CHECK_EN
    if (cnt != 65535) begin
      if (exp_seq != 0 && seq != exp_seq) v[4] = 1'b1;
      exp_seq = seq + 64'(cnt);
    end
`endif
    if (cnt == 0) v[3] = 1'b1;
    else if (cnt == 65535) v[2] = 1'b1;
    else if (n == H + 20 && has_last) v[0] = 1'b1;
    if (v != '0) pq.push_back(v);
    if (cnt == 0 || cnt == 65535) return;
    p = H + 20;
    idx = 0;
    while (idx < cnt) begin
      if (p >= n - 1) begin
        if (has_last && !(idx == 0 && p >= n)) pq.push_back(P_TRUNC);
        return;
      end
      len = int'({frame[p], frame[p+1]});
      if (len == 0 || len > MAXL) begin
        v = P_ELEN;
        if (has_last && p + 1 == n - 1) v[0] = 1'b1;
        pq.push_back(v);
        return;
      end
      if (p + 1 == n - 1) begin
        if (has_last) pq.push_back(P_TRUNC);
        return;
      end
      avail = n - (p + 2);
      k = (avail < len) ? avail : len;
      for (int j = 0; j < k; j++) begin
        r.b     = frame[p+2+j];
        r.first = (j == 0);
        r.last  = (j == len - 1) || (has_last && j == k - 1);
        r.len   = LW'(len);
        r.seq   = seq + 64'(idx);
        r.ses   = ses;
        bq.push_back(r);
      end
      if (avail < len) begin
        if (has_last) pq.push_back(P_TRUNC);
        return;
      end
      p += 2 + len;
      idx++;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic build(input logic [63:0] seq, input logic [15:0] cnt);
    int udp;
    logic [79:0] ses;
    frame.delete();
    udp = 28;
    foreach (lens[i]) udp += 2 + blen(lens[i]);
    for (int i = 0; i < H; i++) frame.push_back(8'($urandom));
    frame[H-4] = 8'(udp >> 8);
    frame[H-3] = 8'(udp);
    ses = {16'($urandom), 32'($urandom), 32'($urandom)};
    for (int i = 9; i >= 0; i--) frame.push_back(ses[i*8 +: 8]);
    for (int i = 7; i >= 0; i--) frame.push_back(seq[i*8 +: 8]);
    frame.push_back(cnt[15:8]);
    frame.push_back(cnt[7:0]);
    foreach (lens[i]) begin
      frame.push_back(8'(lens[i] >> 8));
      frame.push_back(8'(lens[i]));
      for (int j = 0; j < blen(lens[i]); j++) begin
        if (j == 0) frame.push_back((i < types.size()) ? types[i] : 8'(65 + $urandom_range(0, 25)));
        else frame.push_back(8'($urandom));
      end
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit last, input int gm);
    int g;
    g = 0;
    if (gm == 1) g = 1;
    else if (gm == 2 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
    idle(g);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_last  = last;
  endtask

  task automatic send(input int n, input bit has_last, input int gm);
    model_frame(n, has_last);
    for (int i = 0; i < n; i++) drive_byte(frame[i], has_last && (i == n - 1), gm);
    idle(1);
  endtask

  task automatic check_reset_state();
    checks++;
    if ({bus.out_valid, bus.out_first, bus.out_last} !== 3'b000 || bus.out_byte !== 8'h00 || bus.out_len !== '0) begin
      errors++;
      $display("FAIL reset_out: got v=%0b f=%0b l=%0b b=%02h len=%0d, required all 0",
               bus.out_valid, bus.out_first, bus.out_last, bus.out_byte, bus.out_len);
    end
    checks++;
    if (bus.out_seq !== 64'h0) begin
      errors++;
      $display("FAIL reset_seq: got %h, required 0", bus.out_seq);
    end
    checks++;
    if (bus.out_session !== 80'h0) begin
      errors++;
      $display("FAIL reset_session: got %h, required 0", bus.out_session);
    end
    checks++;
    if ({seq_gap, hb_pulse, eos_pulse, err_len, err_trunc} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %05b, required 00000", {seq_gap, hb_pulse, eos_pulse, err_len, err_trunc});
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset   = 1'b1;
    exp_seq = '0;
    #2;
    check_reset_state();
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1);
  end

  initial begin
    int mode, nm, cut, n;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_byte  = '0;
    bus.in_last  = 1'b0;
    #23;
    check_reset_state();
    #4;
    reset = 1'b0;
    idle(2);

    // Two messages 'S'(12) and 'A'(36), back-to-back then with alternating in_valid gaps.
    lens = '{12, 36};
    types = '{8'h53, 8'h41};
    build(64'h10, 16'd2);
    send(frame.size(), 1, 0);
    send(frame.size(), 1, 1);
    types.delete();

    lens.delete();
    build(64'h20, 16'h0000);
    send(frame.size(), 1, 0);
    build(64'h21, 16'hFFFF);
    send(frame.size(), 1, 2);

    lens = '{16'h50, 5};
    build(64'h30, 16'd2);
    send(frame.size(), 1, 0);
    lens = '{3, 1, 64};
    build(64'h31, 16'd3);
    send(frame.size(), 1, 2);

    // Frame ends on the 5th byte of a 12-byte message.
    lens = '{12};
    build(64'h40, 16'd1);
    send(H + 20 + 2 + 5, 1, 0);
    lens = '{7, 9};
    build(64'h41, 16'd2);
    send(frame.size(), 1, 0);

    lens = '{20, 20};
    build(64'h50, 16'd2);
    send(H + 20 + 2 + 7, 0, 0);
    do_reset();
    lens = '{10};
    build(64'h51, 16'd1);
    send(frame.size(), 1, 0);

    do_reset();
    lens = '{4, 4, 4};
    build(64'd1, 16'd3);
    send(frame.size(), 1, 0);
    lens = '{4};
    build(64'd5, 16'd1);
    send(frame.size(), 1, 0);
    do_reset();
    lens = '{4, 4, 4};
    build(64'd1, 16'd3);
    send(frame.size(), 1, 0);
    lens = '{4};
    build(64'd4, 16'd1);
    send(frame.size(), 1, 0);

    for (int f = 0; f < 40; f++) begin
      mode = $urandom_range(0, 9);
      lens.delete();
      if (mode == 0) begin
        build({32'($urandom), 32'($urandom)}, 16'h0000);
      end else if (mode == 1) begin
        build({32'($urandom), 32'($urandom)}, 16'hFFFF);
      end else begin
        nm = $urandom_range(1, 4);
        for (int m = 0; m < nm; m++) begin
          if ($urandom_range(0, 15) == 0) lens.push_back(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(65, 200));
          else lens.push_back($urandom_range(1, MAXL));
        end
        build({32'($urandom), 32'($urandom)}, 16'(nm));
      end
      cut = $urandom_range(0, 5);
      n = frame.size();
      if (cut == 0) begin
        n = $urandom_range(1, frame.size());
      end else if (cut == 1) begin
        repeat ($urandom_range(1, 5)) frame.push_back(8'($urandom));
        n = frame.size();
      end
      send(n, 1, $urandom_range(0, 2));
    end

    idle(20);
    checks++;
    if (bq.size() != 0) begin
      errors++;
      $display("FAIL bytes_outstanding: %0d expected bytes never emitted, required 0", bq.size());
    end
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL pulses_outstanding: %0d expected pulses never seen, required 0", pq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
